// File: rtl/ones_count_ctrl_if.sv
// -----------------------------------------------------------------------------
// ones_count_ctrl_if
//
// Purpose:
//   Groups the request and control signals of the ones-count controller so
//   the requester and the controller share one bundle.
//
// Signals:
//   start          requester -> controller : request a scan of data_in
//   data_in[W-1:0] requester -> controller : word to scan, captured on accept
//   clear_counter  controller -> requester : clear the downstream bit counter
//   inc_counter    controller -> requester : increment the downstream counter
//   busy           controller -> requester : high whenever not idle
//   done           controller -> requester : one-cycle completion pulse
//
// Modports:
//   master : the requester / surrounding logic
//   slave  : the ones_count_ctrl instance
// -----------------------------------------------------------------------------
interface ones_count_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             clear_counter;
  logic             inc_counter;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output data_in,
    input  clear_counter,
    input  inc_counter,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output clear_counter,
    output inc_counter,
    output busy,
    output done
  );

endinterface : ones_count_ctrl_if

// File: rtl/ones_count_ctrl.sv
// -----------------------------------------------------------------------------
// ones_count_ctrl
//
// Purpose:
//   Control FSM that counts the ones in a WIDTH-bit word by driving an
//   external 8-bit bit counter. A scan clears the counter for one cycle,
//   then shifts the captured word right once per cycle, pulsing inc_counter
//   whenever the bit leaving the bottom is a one, and finally pulses done
//   while the counter holds the popcount.
//
//   States: IDLE -> CLEAR (1 cycle) -> SHIFT (WIDTH cycles) -> DONE (1 cycle)
//
// Parameters:
//   WIDTH  bits per input word, legal range 2..255 (default 8)
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high reset
//   bus    ones_count_ctrl_if.slave: start, data_in in;
//          clear_counter, inc_counter, busy, done out
//
// Build option:
//   ONES_COUNT_ZERO_SKIP_EN  when defined, SHIFT ends as soon as the
//   remaining shift register is all zeros, so DONE can arrive early. The
//   popcount delivered is unchanged; only DONE timing moves.
//
// All four outputs are flops loaded from the next-state decode, so they
// line up cycle-for-cycle with the state they describe.
// -----------------------------------------------------------------------------
module ones_count_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  ones_count_ctrl_if.slave bus
);

  // Bit index counter is just wide enough to reach WIDTH-1.
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             clear_counter_q, clear_counter_d;
  logic             inc_counter_q, inc_counter_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             zero_skip;

  // Early-exit condition: only live when the zero-skip build option is on.
`ifdef ONES_COUNT_ZERO_SKIP_EN
  assign zero_skip = (shreg_q == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Next-state, shift register and bit index update.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_CLEAR;
          shreg_d   = bus.data_in;
          bit_cnt_d = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (zero_skip) begin
          // Nothing left to count: finish now, register stays all zero.
          state_d = ST_DONE;
        end else if (bit_cnt_q == LAST_CNT) begin
          // Final bit: hold the index so it never wraps inside a scan.
          shreg_d = shreg_q >> 1;
          state_d = ST_DONE;
        end else begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          state_d   = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the state and shift register about to be loaded.
  always_comb begin
    clear_counter_d = 1'b0;
    inc_counter_d   = 1'b0;
    busy_d          = 1'b0;
    done_d          = 1'b0;

    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end

      ST_CLEAR: begin
        busy_d          = 1'b1;
        clear_counter_d = 1'b1;
      end

      ST_SHIFT: begin
        // Bit 0 of the register entering this SHIFT cycle is the bit counted.
        busy_d        = 1'b1;
        inc_counter_d = shreg_d[0];
      end

      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      shreg_q         <= '0;
      bit_cnt_q       <= '0;
      clear_counter_q <= 1'b0;
      inc_counter_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      bit_cnt_q       <= bit_cnt_d;
      clear_counter_q <= clear_counter_d;
      inc_counter_q   <= inc_counter_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.clear_counter = clear_counter_q;
  assign bus.inc_counter   = inc_counter_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule : ones_count_ctrl

// File: tb/tb_ones_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ones_count_ctrl
//
// Bench for ones_count_ctrl at WIDTH=8. Each accepted scan pushes its word,
// expected popcount, expected DONE offset and acceptance edge into a
// scoreboard. A monitor on the falling edge derives the expected value of
// every output from the head entry and compares all four outputs each cycle,
// plus the downstream counter value (modelled here) when DONE is due.
// -----------------------------------------------------------------------------
module tb_ones_count_ctrl;

  localparam int W = 8;

`ifdef ONES_COUNT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    int         cnt;
    int         lat_full;
    int         lat_skip;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         cnt;
    int         lat;
    int         acc;
  } sb_t;

  logic clk;
  logic reset;

  ones_count_ctrl_if #(.WIDTH(W)) bus ();

  ones_count_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_vec  = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   model_cnt = 0;
  sb_t  sbq[$];
  vec_t tbl[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and downstream 8-bit bit counter model.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt = edge_cnt + 1;
      if (reset || bus.clear_counter) model_cnt = 0;
      else if (bus.inc_counter) model_cnt = (model_cnt + 1) % 256;
    end
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, edge_cnt, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: expected outputs come from the scoreboard head every cycle.
  initial begin
    logic e_clr, e_inc, e_busy, e_done;
    int off;
    forever begin
      @(negedge clk);
      e_clr = 1'b0; e_inc = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      off = -1;
      if (sbq.size() > 0) begin
        off = edge_cnt - sbq[0].acc;
        if (off >= 0) begin
          e_busy = 1'b1;
          e_clr  = (off == 0);
          e_inc  = (off >= 1 && off <= W) ? sbq[0].data[off-1] : 1'b0;
          e_done = (off == sbq[0].lat);
        end
      end
      chk_bit("clear_counter", bus.clear_counter, e_clr);
      chk_bit("inc_counter",   bus.inc_counter,   e_inc);
      chk_bit("busy",          bus.busy,          e_busy);
      chk_bit("done",          bus.done,          e_done);
      if (e_done) begin
        chk_int("count_at_done", model_cnt, sbq[0].cnt);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input int cnt, input int lat, input int acc);
    sb_t e;
    e.data = d; e.cnt = cnt; e.lat = lat; e.acc = acc;
    sbq.push_back(e);
  endtask

  task automatic start_scan(input logic [7:0] d, input int cnt, input int lat);
    @(negedge clk); #1;
    bus.start   = 1'b1;
    bus.data_in = d;
    push_exp(d, cnt, lat, edge_cnt + 1);
    @(negedge clk); #1;
    bus.start   = 1'b0;
    bus.data_in = 8'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (sbq.size() != 0 && i < 60) begin
      @(negedge clk); #2;
      i++;
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scan_timeout edge=%0d got=%0d pending expected=0 pending", edge_cnt, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    sb_t  head;
    int   acc1, acc2, lat1, lat2;

    tbl[0] = '{8'hB5, 5, 9, 9};
    tbl[1] = '{8'hFF, 8, 9, 9};
    tbl[2] = '{8'h00, 0, 9, 2};
    tbl[3] = '{8'h01, 1, 9, 3};
    tbl[4] = '{8'h80, 1, 9, 9};
    tbl[5] = '{8'h0F, 4, 9, 6};
    tbl[6] = '{8'h3C, 4, 9, 8};
    tbl[7] = '{8'hAA, 4, 9, 9};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    // Start high during reset must be ignored.
    bus.start   = 1'b1;
    bus.data_in = 8'hFF;
    @(negedge clk); #1;
    bus.start   = 1'b0;
    reset       = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven scans.
    for (int v = 0; v < 8; v++) begin
      start_scan(tbl[v].data, tbl[v].cnt, SKIP ? tbl[v].lat_skip : tbl[v].lat_full);
      wait_idle();
    end

    // Start pulse with new data mid-scan is ignored.
    start_scan(8'hB5, 5, 9);
    repeat (2) @(negedge clk);
    #1;
    bus.start   = 1'b1;
    bus.data_in = 8'hFF;
    @(negedge clk); #1;
    bus.start   = 1'b0;
    wait_idle();

    // Start held through DONE: second scan one IDLE cycle later.
    lat1 = SKIP ? 6 : 9;
    lat2 = SKIP ? 8 : 9;
    @(negedge clk); #1;
    acc1 = edge_cnt + 1;
    acc2 = acc1 + lat1 + 2;
    bus.start   = 1'b1;
    bus.data_in = 8'h0F;
    push_exp(8'h0F, 4, lat1, acc1);
    push_exp(8'h33, 4, lat2, acc2);
    @(negedge clk); #1;
    bus.data_in = 8'h33;
    for (int i = 0; i < 40 && edge_cnt < acc2; i++) begin
      @(negedge clk); #1;
    end
    bus.start = 1'b0;
    wait_idle();

    // Reset mid-SHIFT aborts without done, then a fresh scan works.
    start_scan(8'hB5, 5, 9);
    head = sbq[0];
    for (int i = 0; i < 20 && edge_cnt < head.acc + 4; i++) begin
      @(negedge clk); #1;
    end
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.data_in = 8'h77;
    sbq.delete();
    @(negedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    start_scan(8'h0F, 4, SKIP ? 6 : 9);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_ones_count_ctrl
